// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-read-latency word memory between instruction
// fetch (IF) and load/store (D). D has priority. IF is forced ahead once it has
// been denied STARVE_MAX cycles in a row. Read data is steered back to the
// requester that issued the read through a small owner register.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// OWN_NONE | no read in flight; MEM_RDATA is ignored this cycle
// OWN_IF   | fetch read issued last cycle; MEM_RDATA goes to IF_RDATA
// OWN_D    | data read issued last cycle; MEM_RDATA goes to D_RDATA
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             IF_REQ,
   input  logic [AW-1:0]    IF_ADDR,
   output logic             IF_GNT,
   output logic             IF_RVALID,
   output logic [31:0]      IF_RDATA,
   input  logic             D_REQ,
   input  logic [AW-1:0]    D_ADDR,
   input  logic [3:0]       D_BE,
   input  logic [31:0]      D_WDATA,
   output logic             D_GNT,
   output logic             D_RVALID,
   output logic [31:0]      D_RDATA,
   output logic             MEM_EN,
   output logic [3:0]       MEM_WE,
   output logic [AW-3:0]    MEM_ADDR,
   output logic [31:0]      MEM_WDATA,
   input  logic [31:0]      MEM_RDATA,
   output logic [CNT_W-1:0] CONFLICT_CNT
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   owner_t        owner, owner_nxt;
   logic [SW-1:0] starve_cnt;
   logic          starved;

   // Word addressing drops the byte offset bits.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{IF_ADDR[1:0], D_ADDR[1:0]};

   assign starved = (starve_cnt == SW'(STARVE_MAX));

   // Owner register: remembers whose read is on the memory output this cycle.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         owner <= OWN_NONE;
      end else begin
         owner <= owner_nxt;
      end
   end

   // Arbitration, memory drive, next owner and read-data steering.
   always_comb begin
      IF_GNT    = 1'b0;
      D_GNT     = 1'b0;
      MEM_EN    = 1'b0;
      MEM_WE    = 4'b0000;
      MEM_ADDR  = '0;
      MEM_WDATA = 32'h0;
      owner_nxt = OWN_NONE;
      IF_RVALID = 1'b0;
      IF_RDATA  = 32'h0;
      D_RVALID  = 1'b0;
      D_RDATA   = 32'h0;

      // Grants are suppressed while reset is asserted so nothing reaches memory.
      if (RSTN) begin
         if (IF_REQ && (!D_REQ || starved)) begin
            IF_GNT = 1'b1;
         end else if (D_REQ) begin
            D_GNT = 1'b1;
         end
      end

      if (IF_GNT) begin
         MEM_EN    = 1'b1;
         MEM_ADDR  = IF_ADDR[AW-1:2];
         owner_nxt = OWN_IF;
      end else if (D_GNT) begin
         MEM_EN    = 1'b1;
         MEM_WE    = D_BE;
         MEM_ADDR  = D_ADDR[AW-1:2];
         MEM_WDATA = D_WDATA;
         // Writes complete at grant and produce no response.
         if (D_BE == 4'b0000) begin
            owner_nxt = OWN_D;
         end
      end

      case (owner)
         OWN_IF: begin
            IF_RVALID = 1'b1;
            IF_RDATA  = MEM_RDATA;
         end
         OWN_D: begin
            D_RVALID = 1'b1;
            D_RDATA  = MEM_RDATA;
         end
         default: ;
      endcase
   end

   // Starve counter: counts consecutive denied fetch cycles, saturates at STARVE_MAX.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         starve_cnt <= '0;
      end else if (!IF_REQ || IF_GNT) begin
         starve_cnt <= '0;
      end else if (!starved) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Conflict counter: cycles with both requesters active, sticks at all-ones.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         CONFLICT_CNT <= '0;
      end else if (IF_REQ && D_REQ && (CONFLICT_CNT != '1)) begin
         CONFLICT_CNT <= CONFLICT_CNT + 1'b1;
      end
   end

endmodule
